// File: rtl/ultrasonic_echo_gen_if.sv
// Bus between a ranging master and the ultrasonic echo responder.
// The master drives trigger, enable and emulated distance. The responder
// returns the echo pulse and its status strobes.
interface ultrasonic_echo_gen_if;
    logic       TRIG;
    logic       ENABLE;
    logic [7:0] DIST;
    logic       ECHO;
    logic       BUSY;
    logic       ECHO_DONE;
    logic       SHORT_TRIG;

    modport master (
        output TRIG,
        output ENABLE,
        output DIST,
        input  ECHO,
        input  BUSY,
        input  ECHO_DONE,
        input  SHORT_TRIG
    );

    modport slave (
        input  TRIG,
        input  ENABLE,
        input  DIST,
        output ECHO,
        output BUSY,
        output ECHO_DONE,
        output SHORT_TRIG
    );
endinterface

// File: rtl/ultrasonic_echo_gen.sv
// Ultrasonic ranging sensor emulator (HC-SR04 style responder).
// A TRIG pulse that is high for long enough is followed by a fixed burst delay.
// After the delay, ECHO goes high for a time proportional to the distance
// latched when TRIG fell. A hold-off period follows, during which new
// triggers are ignored.
// All outputs come straight from flops.
module ultrasonic_echo_gen #(
    parameter int unsigned TRIG_MIN     = 10,
    parameter int unsigned BURST_DLY    = 8,
    parameter int unsigned TICKS_PER_CM = 1,
    parameter int unsigned HOLDOFF      = 20,
    parameter int unsigned NO_ECHO_W    = 255
) (
    input  logic                 CLKOUTD,
    input  logic                 reset,
    ultrasonic_echo_gen_if.slave bus
);
    localparam logic [15:0] TRIG_MIN_C = 16'(TRIG_MIN);
    localparam logic [15:0] BURST_LD   = (BURST_DLY > 0) ? 16'(BURST_DLY - 1) : 16'd0;
    localparam logic [15:0] HOLD_LD    = (HOLDOFF > 0) ? 16'(HOLDOFF - 1) : 16'd0;
    localparam logic [15:0] TICKS_C    = 16'(TICKS_PER_CM);
    localparam logic [7:0]  NO_ECHO_C  = 8'(NO_ECHO_W);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO_ON,
        HOLD
    } state_t;

    state_t      state, state_n;
    logic [15:0] trig_cnt, trig_cnt_n;   // TRIG high time, saturating at TRIG_MIN
    logic [15:0] tmr, tmr_n;             // down-counter shared by BURST, ECHO_ON and HOLD
    logic [7:0]  dist_lat, dist_lat_n;   // distance frozen at trigger acceptance
    logic        armed, armed_n;         // TRIG seen low in IDLE, so a rising edge is fresh
    logic        echo, echo_n;
    logic        busy, busy_n;
    logic        done, done_n;
    logic        short_trig, short_n;

    // Trigger length counter: count up, then stick at the threshold.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c >= TRIG_MIN_C) ? TRIG_MIN_C : c + 16'd1;
    endfunction

    // Echo width in clocks. Distance 0 means no target, which gives the long
    // timeout pulse. 255 * 255 still fits in 16 bits.
    function automatic logic [15:0] echo_width(input logic [7:0] d);
        logic [7:0] units;
        units = (d == 8'd0) ? NO_ECHO_C : d;
        return 16'(units) * TICKS_C;
    endfunction

    // Next-state and next-output decode. Strobes default low and every
    // register holds unless a transition updates it.
    always_comb begin
        state_n    = state;
        trig_cnt_n = trig_cnt;
        tmr_n      = tmr;
        dist_lat_n = dist_lat;
        armed_n    = armed;
        echo_n     = echo;
        done_n     = 1'b0;
        short_n    = 1'b0;

        case (state)
            IDLE: begin
                // TRIG must be seen low here before a high level counts. So a
                // TRIG still high after reset or after hold-off is not a trigger.
                if (!bus.TRIG) begin
                    armed_n = 1'b1;
                end else if (bus.ENABLE && armed) begin
                    state_n    = TRIG_HI;
                    trig_cnt_n = 16'd1;
                    armed_n    = 1'b0;
                end
            end

            TRIG_HI: begin
                if (bus.TRIG) begin
                    trig_cnt_n = sat_inc(trig_cnt);
                end else if (trig_cnt >= TRIG_MIN_C) begin
                    dist_lat_n = bus.DIST;
                    trig_cnt_n = 16'd0;
                    if (BURST_DLY == 0) begin
                        state_n = ECHO_ON;
                        echo_n  = 1'b1;
                        tmr_n   = echo_width(bus.DIST) - 16'd1;
                    end else begin
                        state_n = BURST;
                        tmr_n   = BURST_LD;
                    end
                end else begin
                    // TRIG is low right now, so the next rising edge is a fresh one.
                    state_n    = IDLE;
                    short_n    = 1'b1;
                    armed_n    = 1'b1;
                    trig_cnt_n = 16'd0;
                end
            end

            BURST: begin
                if (tmr == 16'd0) begin
                    state_n = ECHO_ON;
                    echo_n  = 1'b1;
                    tmr_n   = echo_width(dist_lat) - 16'd1;
                end else begin
                    tmr_n = tmr - 16'd1;
                end
            end

            ECHO_ON: begin
                if (tmr == 16'd0) begin
                    echo_n = 1'b0;
                    done_n = 1'b1;
                    if (HOLDOFF == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = HOLD;
                        tmr_n   = HOLD_LD;
                    end
                end else begin
                    tmr_n = tmr - 16'd1;
                end
            end

            HOLD: begin
                if (tmr == 16'd0) begin
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr - 16'd1;
                end
            end

            default: begin
                state_n = IDLE;
                echo_n  = 1'b0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers. Reset clears everything at once, including
    // a pulse that is in flight, and gives no completion strobe.
    always_ff @(posedge CLKOUTD or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            trig_cnt   <= 16'd0;
            tmr        <= 16'd0;
            dist_lat   <= 8'd0;
            armed      <= 1'b0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            short_trig <= 1'b0;
        end else begin
            state      <= state_n;
            trig_cnt   <= trig_cnt_n;
            tmr        <= tmr_n;
            dist_lat   <= dist_lat_n;
            armed      <= armed_n;
            echo       <= echo_n;
            busy       <= busy_n;
            done       <= done_n;
            short_trig <= short_n;
        end
    end

    assign bus.ECHO       = echo;
    assign bus.BUSY       = busy;
    assign bus.ECHO_DONE  = done;
    assign bus.SHORT_TRIG = short_trig;
endmodule

// File: tb/tb_ultrasonic_echo_gen.sv
// Testbench for ultrasonic_echo_gen.
// dut0 uses the default parameters. dut1 uses TICKS_PER_CM=3 and HOLDOFF=0.
// Expected timing comes from the protocol rules: echo rises BURST_DLY cycles
// after the sampled TRIG fall and lasts width cycles, then hold-off follows.
module tb_ultrasonic_echo_gen;
    localparam int TRIG_MIN  = 10;
    localparam int BURST_DLY = 8;
    localparam int HOLDOFF   = 20;
    localparam int NO_ECHO_W = 255;
    localparam int TPC1      = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ultrasonic_echo_gen_if bus0 ();
    ultrasonic_echo_gen_if bus1 ();

    ultrasonic_echo_gen dut0 (
        .CLKOUTD(clk),
        .reset  (reset),
        .bus    (bus0)
    );

    ultrasonic_echo_gen #(
        .TICKS_PER_CM(TPC1),
        .HOLDOFF     (0)
    ) dut1 (
        .CLKOUTD(clk),
        .reset  (reset),
        .bus    (bus1)
    );

    always #5 clk = ~clk;

    // Edge counter: the value seen at a negedge is the number of the rising edge just taken.
    always @(posedge clk) cyc <= cyc + 1;

    wire [1:0] echo_w  = {bus1.ECHO, bus0.ECHO};
    wire [1:0] busy_w  = {bus1.BUSY, bus0.BUSY};
    wire [1:0] done_w  = {bus1.ECHO_DONE, bus0.ECHO_DONE};
    wire [1:0] short_w = {bus1.SHORT_TRIG, bus0.SHORT_TRIG};

    int rises[2];
    int rise_cyc[2];
    int hi_cnt[2];
    int done_cnt[2];
    int done_cyc[2];
    int short_cnt[2];
    int short_cyc[2];
    int busy_fall[2];
    int busy_hi[2];
    logic [1:0] echo_prev = 2'b00;
    logic [1:0] busy_prev = 2'b00;

    // Event recorder for both responders, sampled on the inactive edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (echo_w[i] === 1'b1 && echo_prev[i] === 1'b0) begin rises[i] = rises[i] + 1; rise_cyc[i] = cyc; end
            if (echo_w[i] === 1'b1) hi_cnt[i] = hi_cnt[i] + 1;
            if (done_w[i] === 1'b1) begin done_cnt[i] = done_cnt[i] + 1; done_cyc[i] = cyc; end
            if (short_w[i] === 1'b1) begin short_cnt[i] = short_cnt[i] + 1; short_cyc[i] = cyc; end
            if (busy_w[i] === 1'b1) busy_hi[i] = busy_hi[i] + 1;
            if (busy_w[i] === 1'b0 && busy_prev[i] === 1'b1) busy_fall[i] = cyc;
        end
        echo_prev = echo_w;
        busy_prev = busy_w;
    end

    // Reference model: echo width in clocks.
    function automatic int model_width(input int d, input int tpc);
        return ((d == 0) ? NO_ECHO_W : d) * tpc;
    endfunction

    task automatic set_trig(input int sel, input logic v);
        if (sel == 0) bus0.TRIG = v; else bus1.TRIG = v;
    endtask

    task automatic set_dist(input int sel, input logic [7:0] d);
        if (sel == 0) bus0.DIST = d; else bus1.DIST = d;
    endtask

    // Hold TRIG high for len sampled edges. fe is the edge that samples the fall.
    task automatic trig_pulse(input int sel, input int len, input logic [7:0] d, output int fe);
        @(negedge clk);
        set_dist(sel, d);
        set_trig(sel, 1'b1);
        repeat (len) @(negedge clk);
        set_trig(sel, 1'b0);
        fe = cyc + 1;
    endtask

    task automatic test_reset();
        int bh;
        reset = 1'b0;
        bus0.TRIG = 1'b0; bus0.ENABLE = 1'b1; bus0.DIST = 8'd0;
        bus1.TRIG = 1'b0; bus1.ENABLE = 1'b1; bus1.DIST = 8'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus0.ECHO, bus0.BUSY, bus0.ECHO_DONE, bus0.SHORT_TRIG} !== 4'b0000) begin n_bad++; $display("FAIL reset_outs0 got=%b exp=0000", {bus0.ECHO, bus0.BUSY, bus0.ECHO_DONE, bus0.SHORT_TRIG}); end
        n_cmp++; if ({bus1.ECHO, bus1.BUSY, bus1.ECHO_DONE, bus1.SHORT_TRIG} !== 4'b0000) begin n_bad++; $display("FAIL reset_outs1 got=%b exp=0000", {bus1.ECHO, bus1.BUSY, bus1.ECHO_DONE, bus1.SHORT_TRIG}); end
        // TRIG already high when reset is released must not start a measurement
        bus0.TRIG = 1'b1;
        bus1.TRIG = 1'b1;
        #1 bh = busy_hi[0] + busy_hi[1];
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        n_cmp++; if (busy_hi[0] + busy_hi[1] - bh !== 0) begin n_bad++; $display("FAIL reset_stale_trig busy_cycles=%0d exp=0", busy_hi[0] + busy_hi[1] - bh); end
        bus0.TRIG = 1'b0;
        bus1.TRIG = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int fe, r0, h0, d0, s0;
        #1; r0 = rises[0]; h0 = hi_cnt[0]; d0 = done_cnt[0]; s0 = short_cnt[0];
        trig_pulse(0, 12, 8'd25, fe);
        for (int k = 0; k < 2000 && busy_w[0]; k++) @(negedge clk);
        n_cmp++; if (busy_w[0] !== 1'b0) begin n_bad++; $display("FAIL basic_timeout busy=%b exp=0", busy_w[0]); end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (rises[0] - r0 !== 1) begin n_bad++; $display("FAIL basic_rises got=%0d exp=1", rises[0] - r0); end
        n_cmp++; if (rise_cyc[0] !== fe + BURST_DLY) begin n_bad++; $display("FAIL basic_rise_time got=%0d exp=%0d", rise_cyc[0], fe + BURST_DLY); end
        n_cmp++; if (hi_cnt[0] - h0 !== 25) begin n_bad++; $display("FAIL basic_width got=%0d exp=25", hi_cnt[0] - h0); end
        n_cmp++; if (done_cnt[0] - d0 !== 1) begin n_bad++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt[0] - d0); end
        n_cmp++; if (done_cyc[0] !== fe + BURST_DLY + 25) begin n_bad++; $display("FAIL basic_done_time got=%0d exp=%0d", done_cyc[0], fe + BURST_DLY + 25); end
        n_cmp++; if (busy_fall[0] !== fe + BURST_DLY + 25 + HOLDOFF) begin n_bad++; $display("FAIL basic_busy_fall got=%0d exp=%0d", busy_fall[0], fe + BURST_DLY + 25 + HOLDOFF); end
        n_cmp++; if (short_cnt[0] - s0 !== 0) begin n_bad++; $display("FAIL basic_short got=%0d exp=0", short_cnt[0] - s0); end
    endtask

    task automatic test_short_trig();
        int fe, r0, s0;
        int lens[3] = '{1, 5, TRIG_MIN - 1};
        foreach (lens[j]) begin
            #1; r0 = rises[0]; s0 = short_cnt[0];
            trig_pulse(0, lens[j], 8'd60, fe);
            repeat (12) @(negedge clk);
            #1;
            n_cmp++; if (short_cnt[0] - s0 !== 1) begin n_bad++; $display("FAIL short_count len=%0d got=%0d exp=1", lens[j], short_cnt[0] - s0); end
            n_cmp++; if (short_cyc[0] !== fe) begin n_bad++; $display("FAIL short_time len=%0d got=%0d exp=%0d", lens[j], short_cyc[0], fe); end
            n_cmp++; if (busy_fall[0] !== fe) begin n_bad++; $display("FAIL short_busy_fall len=%0d got=%0d exp=%0d", lens[j], busy_fall[0], fe); end
            n_cmp++; if (rises[0] - r0 !== 0) begin n_bad++; $display("FAIL short_echo len=%0d got=%0d exp=0", lens[j], rises[0] - r0); end
        end
    endtask

    task automatic test_random();
        int sel, len, tpc, hold, w, fe, r0, h0, d0, s0;
        logic [7:0] d;
        bit valid;
        for (int it = 0; it < 8; it++) begin
            sel = int'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            len = int'($urandom_range(6, 16));
            if (it == 0) len = TRIG_MIN - 1;
            if (it == 1) len = TRIG_MIN;
            tpc = (sel == 0) ? 1 : TPC1;
            hold = (sel == 0) ? HOLDOFF : 0;
            valid = (len >= TRIG_MIN);
            w = model_width(int'(d), tpc);
            #1; r0 = rises[sel]; h0 = hi_cnt[sel]; d0 = done_cnt[sel]; s0 = short_cnt[sel];
            trig_pulse(sel, len, d, fe);
            @(negedge clk);
            set_dist(sel, 8'($urandom_range(0, 255)));
            for (int k = 0; k < 2000 && busy_w[sel]; k++) @(negedge clk);
            n_cmp++; if (busy_w[sel] !== 1'b0) begin n_bad++; $display("FAIL rand_timeout it=%0d busy=%b exp=0", it, busy_w[sel]); end
            repeat (2) @(negedge clk);
            #1;
            if (valid) begin
                n_cmp++; if (rise_cyc[sel] !== fe + BURST_DLY) begin n_bad++; $display("FAIL rand_rise it=%0d got=%0d exp=%0d", it, rise_cyc[sel], fe + BURST_DLY); end
                n_cmp++; if (hi_cnt[sel] - h0 !== w) begin n_bad++; $display("FAIL rand_width it=%0d dist=%0d got=%0d exp=%0d", it, d, hi_cnt[sel] - h0, w); end
                n_cmp++; if (done_cnt[sel] - d0 !== 1) begin n_bad++; $display("FAIL rand_done it=%0d got=%0d exp=1", it, done_cnt[sel] - d0); end
                n_cmp++; if (busy_fall[sel] !== fe + BURST_DLY + w + hold) begin n_bad++; $display("FAIL rand_busy_fall it=%0d got=%0d exp=%0d", it, busy_fall[sel], fe + BURST_DLY + w + hold); end
            end else begin
                n_cmp++; if (short_cnt[sel] - s0 !== 1) begin n_bad++; $display("FAIL rand_short it=%0d got=%0d exp=1", it, short_cnt[sel] - s0); end
                n_cmp++; if (rises[sel] - r0 !== 0) begin n_bad++; $display("FAIL rand_no_echo it=%0d got=%0d exp=0", it, rises[sel] - r0); end
            end
        end
    endtask

    task automatic test_no_target();
        int sels[3] = '{0, 1, 1};
        int dists[3] = '{0, 255, 0};
        int fe, h0, w, hold;
        foreach (sels[j]) begin
            w = model_width(dists[j], (sels[j] == 0) ? 1 : TPC1);
            hold = (sels[j] == 0) ? HOLDOFF : 0;
            #1; h0 = hi_cnt[sels[j]];
            trig_pulse(sels[j], 12, 8'(dists[j]), fe);
            for (int k = 0; k < 2000 && busy_w[sels[j]]; k++) @(negedge clk);
            n_cmp++; if (busy_w[sels[j]] !== 1'b0) begin n_bad++; $display("FAIL wide_timeout case=%0d busy=%b exp=0", j, busy_w[sels[j]]); end
            repeat (2) @(negedge clk);
            #1;
            n_cmp++; if (hi_cnt[sels[j]] - h0 !== w) begin n_bad++; $display("FAIL wide_width case=%0d got=%0d exp=%0d", j, hi_cnt[sels[j]] - h0, w); end
            n_cmp++; if (busy_fall[sels[j]] !== fe + BURST_DLY + w + hold) begin n_bad++; $display("FAIL wide_busy_fall case=%0d got=%0d exp=%0d", j, busy_fall[sels[j]], fe + BURST_DLY + w + hold); end
        end
    endtask

    task automatic test_dist_change();
        int fe, r0, h0, d0, bh;
        #1; r0 = rises[0]; h0 = hi_cnt[0]; d0 = done_cnt[0];
        trig_pulse(0, 12, 8'd40, fe);
        // Toggle TRIG through BURST, ECHO_ON and early HOLD. Then hold it high across the hold-off exit.
        for (int k = 0; k < 55; k++) begin
            @(negedge clk);
            if (cyc == fe + 2) bus0.DIST = 8'd90;
            bus0.TRIG = 1'($urandom_range(0, 1));
        end
        bus0.TRIG = 1'b1;
        for (int k = 0; k < 2000 && busy_w[0]; k++) @(negedge clk);
        n_cmp++; if (busy_w[0] !== 1'b0) begin n_bad++; $display("FAIL dchg_timeout busy=%b exp=0", busy_w[0]); end
        #1; bh = busy_hi[0];
        repeat (30) @(negedge clk);
        #1;
        n_cmp++; if (hi_cnt[0] - h0 !== 40) begin n_bad++; $display("FAIL dchg_width got=%0d exp=40", hi_cnt[0] - h0); end
        n_cmp++; if (rises[0] - r0 !== 1) begin n_bad++; $display("FAIL dchg_rises got=%0d exp=1", rises[0] - r0); end
        n_cmp++; if (done_cnt[0] - d0 !== 1) begin n_bad++; $display("FAIL dchg_done got=%0d exp=1", done_cnt[0] - d0); end
        n_cmp++; if (busy_hi[0] - bh !== 0) begin n_bad++; $display("FAIL dchg_retrigger busy_cycles=%0d exp=0", busy_hi[0] - bh); end
        bus0.TRIG = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_enable();
        int fe, r0, h0, d0, s0, bh;
        bus0.ENABLE = 1'b0;
        #1; r0 = rises[0]; s0 = short_cnt[0]; bh = busy_hi[0];
        trig_pulse(0, 12, 8'd30, fe);
        repeat (40) @(negedge clk);
        #1;
        n_cmp++; if (busy_hi[0] - bh !== 0) begin n_bad++; $display("FAIL en_off_busy got=%0d exp=0", busy_hi[0] - bh); end
        n_cmp++; if (rises[0] - r0 + short_cnt[0] - s0 !== 0) begin n_bad++; $display("FAIL en_off_activity got=%0d exp=0", rises[0] - r0 + short_cnt[0] - s0); end
        bus0.ENABLE = 1'b1;
        repeat (2) @(negedge clk);
        #1; h0 = hi_cnt[0]; d0 = done_cnt[0];
        trig_pulse(0, 12, 8'd30, fe);
        for (int k = 0; k < 100 && !echo_w[0]; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        bus0.ENABLE = 1'b0;
        for (int k = 0; k < 2000 && busy_w[0]; k++) @(negedge clk);
        n_cmp++; if (busy_w[0] !== 1'b0) begin n_bad++; $display("FAIL en_drop_timeout busy=%b exp=0", busy_w[0]); end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (hi_cnt[0] - h0 !== 30) begin n_bad++; $display("FAIL en_drop_width got=%0d exp=30", hi_cnt[0] - h0); end
        n_cmp++; if (done_cnt[0] - d0 !== 1) begin n_bad++; $display("FAIL en_drop_done got=%0d exp=1", done_cnt[0] - d0); end
        n_cmp++; if (busy_fall[0] !== fe + BURST_DLY + 30 + HOLDOFF) begin n_bad++; $display("FAIL en_drop_busy_fall got=%0d exp=%0d", busy_fall[0], fe + BURST_DLY + 30 + HOLDOFF); end
        bus0.ENABLE = 1'b1;
    endtask

    task automatic test_reset_mid_echo();
        int fe, r0, h0, d0;
        #1; r0 = rises[0]; h0 = hi_cnt[0]; d0 = done_cnt[0];
        trig_pulse(0, 12, 8'd25, fe);
        for (int k = 0; k < 200 && cyc < fe + BURST_DLY + 9; k++) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus0.ECHO !== 1'b0) begin n_bad++; $display("FAIL rst_echo_async got=%b exp=0", bus0.ECHO); end
        n_cmp++; if (bus0.BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_busy_async got=%b exp=0", bus0.BUSY); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_cmp++; if (hi_cnt[0] - h0 !== 10) begin n_bad++; $display("FAIL rst_partial_width got=%0d exp=10", hi_cnt[0] - h0); end
        n_cmp++; if (done_cnt[0] - d0 !== 0) begin n_bad++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt[0] - d0); end
        n_cmp++; if (bus0.BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_idle_after got=%b exp=0", bus0.BUSY); end
        // A fresh trigger after release must run normally.
        h0 = hi_cnt[0]; d0 = done_cnt[0];
        trig_pulse(0, 11, 8'd7, fe);
        for (int k = 0; k < 2000 && busy_w[0]; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (hi_cnt[0] - h0 !== 7) begin n_bad++; $display("FAIL rst_recover_width got=%0d exp=7", hi_cnt[0] - h0); end
        n_cmp++; if (done_cnt[0] - d0 !== 1) begin n_bad++; $display("FAIL rst_recover_done got=%0d exp=1", done_cnt[0] - d0); end
        n_cmp++; if (rises[0] - r0 !== 2) begin n_bad++; $display("FAIL rst_rises got=%0d exp=2", rises[0] - r0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_trig();
        test_random();
        test_no_target();
        test_dist_change();
        test_enable();
        test_reset_mid_echo();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time=%0t limit=900000", $time);
        $fatal(1, "simulation time limit reached");
    end
endmodule
